phase_pair_generator: RTL and testbench

- Generates two square waves, Phase1 and Phase2, with a programmable half-period and a programmable phase offset.
- Either output can be selected as the leading one.
- This is the stimulus/transmit end of the phase-measurement path. The offset is expressed in the same CLK-cycle units that the phase detector reports, so loopback through the detector returns PhaseDelay and LeftFirst.
- Default sizing covers 19 kHz at 50 MHz: half-period 1316 cycles.

---
 rtl/phase_pair_generator_if.sv | 27 ++
 rtl/phase_pair_generator.sv | 174 +++++++++++++++++
 tb/tb_phase_pair_generator.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/phase_pair_generator_if.sv
// rtl/phase_pair_generator_if.sv - config handshake and phase output bundle
// Slave side is the generator; master side is whoever programs and observes it.
interface phase_pair_generator_if #(
  parameter int PERIOD_W = 11
) ();
  logic                Enable;
  logic                CfgValid;
  logic                CfgReady;
  logic [PERIOD_W-1:0] HalfPeriod;
  logic [PERIOD_W:0]   PhaseDelay;
  logic                LeftFirst;
  logic                Phase1;
  logic                Phase2;
  logic                Running;
  logic                PeriodDone;
  logic                CfgErr;

  modport master (
    output Enable, CfgValid, HalfPeriod, PhaseDelay, LeftFirst,
    input  CfgReady, Phase1, Phase2, Running, PeriodDone, CfgErr
  );

  modport slave (
    input  Enable, CfgValid, HalfPeriod, PhaseDelay, LeftFirst,
    output CfgReady, Phase1, Phase2, Running, PeriodDone, CfgErr
  );
endinterface

// File: rtl/phase_pair_generator.sv
// rtl/phase_pair_generator.sv - two square waves with programmable half-period and lead/lag offset
// The offset is in clock cycles from the lead rising edge to the lag rising edge.
module phase_pair_generator #(
  parameter int PERIOD_W = 11
) (
  input  logic                  CLK,
  input  logic                  RST,
  phase_pair_generator_if.slave bus
);
  localparam int CW = PERIOD_W + 1;
  localparam logic [CW-1:0] ONE = CW'(1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       lead_cnt_q, lead_cnt_d;
  logic [CW-1:0]       lag_cnt_q, lag_cnt_d;
  logic                lag_armed_q, lag_armed_d;
  logic                held_vld_q, held_vld_d;
  logic [PERIOD_W-1:0] held_h_q, held_h_d;
  logic [CW-1:0]       held_dly_q, held_dly_d;
  logic                held_lf_q, held_lf_d;
  logic                pend_vld_q, pend_vld_d;
  logic [PERIOD_W-1:0] pend_h_q, pend_h_d;
  logic [CW-1:0]       pend_dly_q, pend_dly_d;
  logic                pend_lf_q, pend_lf_d;
  logic                ph1_q, ph1_d;
  logic                ph2_q, ph2_d;
  logic                period_done_q, period_done_d;
  logic                cfg_err_q, cfg_err_d;

  logic          cfg_ready, accept, acc_ok;
  logic [CW-1:0] acc_p, acc_dly, held_p, pend_p;
  logic          lead_wrap, lag_wrap, lead, lag;

  // Lag counter start so that its zero crossing lands d cycles after the lead's.
  function automatic logic [CW-1:0] lag_reload(input logic [CW-1:0] p, input logic [CW-1:0] d);
    lag_reload = (d == '0) ? '0 : p - d;
  endfunction

  assign cfg_ready = ~pend_vld_q;
  assign accept    = bus.CfgValid & cfg_ready;
  assign acc_ok    = accept & (bus.HalfPeriod != '0);
  assign acc_p     = {bus.HalfPeriod, 1'b0};
  assign acc_dly   = (bus.PhaseDelay >= acc_p) ? acc_p - ONE : bus.PhaseDelay;
  assign held_p    = {held_h_q, 1'b0};
  assign pend_p    = {pend_h_q, 1'b0};
  assign lead_wrap = (lead_cnt_q == held_p - ONE);
  assign lag_wrap  = (lag_cnt_q == held_p - ONE);
  assign lead      = (lead_cnt_q < {1'b0, held_h_q});
  assign lag       = lag_armed_q & (lag_cnt_q < {1'b0, held_h_q});

  always_comb begin
    state_d       = state_q;
    lead_cnt_d    = lead_cnt_q;
    lag_cnt_d     = lag_cnt_q;
    lag_armed_d   = lag_armed_q;
    held_vld_d    = held_vld_q;
    held_h_d      = held_h_q;
    held_dly_d    = held_dly_q;
    held_lf_d     = held_lf_q;
    pend_vld_d    = pend_vld_q;
    pend_h_d      = pend_h_q;
    pend_dly_d    = pend_dly_q;
    pend_lf_d     = pend_lf_q;
    ph1_d         = 1'b0;
    ph2_d         = 1'b0;
    period_done_d = 1'b0;
    cfg_err_d     = accept & (bus.HalfPeriod == '0);

    case (state_q)
      S_IDLE: begin
        if (acc_ok) begin
          held_vld_d = 1'b1;
          held_h_d   = bus.HalfPeriod;
          held_dly_d = acc_dly;
          held_lf_d  = bus.LeftFirst;
        end
        if (bus.Enable && (held_vld_q || acc_ok)) begin
          state_d    = S_RUN;
          lead_cnt_d = '0;
          if (acc_ok) begin
            lag_cnt_d   = lag_reload(acc_p, acc_dly);
            lag_armed_d = (acc_dly == '0);
          end else begin
            lag_cnt_d   = lag_reload(held_p, held_dly_q);
            lag_armed_d = (held_dly_q == '0);
          end
        end
      end

      S_RUN, S_DRAIN: begin
        lead_cnt_d    = lead_wrap ? '0 : lead_cnt_q + ONE;
        lag_cnt_d     = lag_wrap ? '0 : lag_cnt_q + ONE;
        lag_armed_d   = lag_armed_q | lag_wrap;
        ph1_d         = held_lf_q ? lead : lag;
        ph2_d         = held_lf_q ? lag : lead;
        period_done_d = lead_wrap;

        if (acc_ok) begin
          pend_vld_d = 1'b1;
          pend_h_d   = bus.HalfPeriod;
          pend_dly_d = acc_dly;
          pend_lf_d  = bus.LeftFirst;
        end
        // A pending config only takes effect on a lead-period boundary.
        if (lead_wrap && pend_vld_q) begin
          pend_vld_d  = 1'b0;
          held_h_d    = pend_h_q;
          held_dly_d  = pend_dly_q;
          held_lf_d   = pend_lf_q;
          lead_cnt_d  = '0;
          lag_cnt_d   = lag_reload(pend_p, pend_dly_q);
          lag_armed_d = (pend_dly_q == '0);
        end

        if (state_q == S_RUN) begin
          if (!bus.Enable) state_d = S_DRAIN;
        end else if (bus.Enable) begin
          state_d = S_RUN;
        end else if (lead_wrap) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= S_IDLE;
      lead_cnt_q    <= '0;
      lag_cnt_q     <= '0;
      lag_armed_q   <= 1'b0;
      held_vld_q    <= 1'b0;
      held_h_q      <= '0;
      held_dly_q    <= '0;
      held_lf_q     <= 1'b0;
      pend_vld_q    <= 1'b0;
      pend_h_q      <= '0;
      pend_dly_q    <= '0;
      pend_lf_q     <= 1'b0;
      ph1_q         <= 1'b0;
      ph2_q         <= 1'b0;
      period_done_q <= 1'b0;
      cfg_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      lead_cnt_q    <= lead_cnt_d;
      lag_cnt_q     <= lag_cnt_d;
      lag_armed_q   <= lag_armed_d;
      held_vld_q    <= held_vld_d;
      held_h_q      <= held_h_d;
      held_dly_q    <= held_dly_d;
      held_lf_q     <= held_lf_d;
      pend_vld_q    <= pend_vld_d;
      pend_h_q      <= pend_h_d;
      pend_dly_q    <= pend_dly_d;
      pend_lf_q     <= pend_lf_d;
      ph1_q         <= ph1_d;
      ph2_q         <= ph2_d;
      period_done_q <= period_done_d;
      cfg_err_q     <= cfg_err_d;
    end
  end

  assign bus.CfgReady   = cfg_ready;
  assign bus.Phase1     = ph1_q;
  assign bus.Phase2     = ph2_q;
  assign bus.Running    = (state_q != S_IDLE);
  assign bus.PeriodDone = period_done_q;
  assign bus.CfgErr     = cfg_err_q;
endmodule

// File: tb/tb_phase_pair_generator.sv
// tb/tb_phase_pair_generator.sv - directed checks of phase_pair_generator waveforms and handshake
// Cycle index c = value seen just after accept edge T+c, i.e. the level sampled at edge T+c+1.
module tb_phase_pair_generator;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  int   cyc;
  int   e_lead, e_lag, e_h;
  logic e_lf;

  phase_pair_generator_if #(.PERIOD_W(11)) bus ();

  phase_pair_generator #(.PERIOD_W(11)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Square wave that first rises at cycle base, high h cycles then low h cycles.
  function automatic logic wave(input int c, input int base, input int h);
    if (c < base) return 1'b0;
    return ((c - base) % (2 * h)) < h;
  endfunction

  task automatic do_reset();
    rst            = 1'b1;
    bus.Enable     = 1'b0;
    bus.CfgValid   = 1'b0;
    bus.HalfPeriod = '0;
    bus.PhaseDelay = '0;
    bus.LeftFirst  = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic start(input int h, input int d, input logic lf);
    bus.HalfPeriod = 11'(h);
    bus.PhaseDelay = 12'(d);
    bus.LeftFirst  = lf;
    bus.CfgValid   = 1'b1;
    bus.Enable     = 1'b1;
    step();
    bus.CfgValid = 1'b0;
    cyc = 0;
  endtask

  task automatic run(input int n);
    logic ld, lg, pd;
    for (int k = 0; k < n; k++) begin
      step();
      cyc++;
      ld = wave(cyc, e_lead, e_h);
      lg = wave(cyc, e_lag, e_h);
      pd = (cyc >= e_lead) && (((cyc - e_lead + 1) % (2 * e_h)) == 0);
      chk($sformatf("phase1@%0d", cyc), 32'(bus.Phase1), 32'(e_lf ? ld : lg));
      chk($sformatf("phase2@%0d", cyc), 32'(bus.Phase2), 32'(e_lf ? lg : ld));
      chk($sformatf("period_done@%0d", cyc), 32'(bus.PeriodDone), 32'(pd));
    end
  endtask

  initial begin
    int rise_lag, fall_lead, k, guard;
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;

    // Reset state
    do_reset();
    chk("rst_phase1", 32'(bus.Phase1), 0);
    chk("rst_phase2", 32'(bus.Phase2), 0);
    chk("rst_running", 32'(bus.Running), 0);
    chk("rst_period_done", 32'(bus.PeriodDone), 0);
    chk("rst_cfg_err", 32'(bus.CfgErr), 0);
    chk("rst_cfg_ready", 32'(bus.CfgReady), 1);

    // H=4 D=2, Phase1 leads
    start(4, 2, 1'b1);
    chk("t1_running", 32'(bus.Running), 1);
    chk("t1_phase1_c0", 32'(bus.Phase1), 0);
    e_lead = 1; e_lag = 3; e_h = 4; e_lf = 1'b1;
    run(24);

    // H=4 D=6, Phase2 leads, no startup fragment on Phase1
    do_reset();
    start(4, 6, 1'b0);
    e_lead = 1; e_lag = 7; e_h = 4; e_lf = 1'b0;
    run(24);

    // H=3 D=9 clamps to 5; then an H=0 config is rejected
    do_reset();
    start(3, 9, 1'b1);
    e_lead = 1; e_lag = 6; e_h = 3; e_lf = 1'b1;
    run(12);
    bus.HalfPeriod = '0;
    bus.PhaseDelay = 12'd0;
    bus.CfgValid   = 1'b1;
    run(1);
    bus.CfgValid = 1'b0;
    chk("cfg_err_pulse", 32'(bus.CfgErr), 1);
    chk("cfg_err_ready", 32'(bus.CfgReady), 1);
    run(1);
    chk("cfg_err_clear", 32'(bus.CfgErr), 0);
    run(10);

    // Mid-period reconfig H=4 -> H=2 D=1
    do_reset();
    start(4, 2, 1'b1);
    e_lead = 1; e_lag = 3; e_h = 4; e_lf = 1'b1;
    run(10);
    bus.HalfPeriod = 11'd2;
    bus.PhaseDelay = 12'd1;
    bus.LeftFirst  = 1'b1;
    bus.CfgValid   = 1'b1;
    run(1);
    bus.CfgValid = 1'b0;
    chk("reconf_ready_low_a", 32'(bus.CfgReady), 0);
    run(4);
    chk("reconf_ready_low_b", 32'(bus.CfgReady), 0);
    run(1);
    chk("reconf_ready_high", 32'(bus.CfgReady), 1);
    e_lead = 17; e_lag = 18; e_h = 2;
    run(12);

    // Enable drop at lead_cnt=2, drain to the wrap, then re-enable
    do_reset();
    start(4, 2, 1'b1);
    e_lead = 1; e_lag = 3; e_h = 4; e_lf = 1'b1;
    run(10);
    bus.Enable = 1'b0;
    run(1);
    chk("drain_running", 32'(bus.Running), 1);
    run(5);
    chk("drain_idle_running", 32'(bus.Running), 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("idle_phase1_%0d", i), 32'(bus.Phase1), 0);
      chk($sformatf("idle_phase2_%0d", i), 32'(bus.Phase2), 0);
    end
    bus.Enable = 1'b1;
    step();
    cyc = 0;
    run(10);

    // Reset while Phase1 is high
    do_reset();
    start(4, 2, 1'b1);
    run(2);
    rst = 1'b1;
    step();
    chk("midrst_phase1", 32'(bus.Phase1), 0);
    chk("midrst_phase2", 32'(bus.Phase2), 0);
    chk("midrst_running", 32'(bus.Running), 0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("norestart_running_%0d", i), 32'(bus.Running), 0);
      chk($sformatf("norestart_phase1_%0d", i), 32'(bus.Phase1), 0);
    end

    // Full-size case: H=1316 D=200, Phase1 leads
    do_reset();
    start(1316, 200, 1'b1);
    guard = 0;
    while (bus.Phase1 !== 1'b1 && guard < 5) begin
      step();
      guard++;
    end
    chk("big_lead_rise_in_time", 32'(guard < 5), 1);
    chk("big_lag_low_at_lead_rise", 32'(bus.Phase2), 0);
    rise_lag  = -1;
    fall_lead = -1;
    k = 0;
    while ((rise_lag < 0 || fall_lead < 0) && k < 3000) begin
      step();
      k++;
      if (rise_lag < 0 && bus.Phase2 === 1'b1) rise_lag = k;
      if (fall_lead < 0 && bus.Phase1 === 1'b0) fall_lead = k;
    end
    chk("big_lag_offset", 32'(rise_lag), 200);
    chk("big_lead_high_len", 32'(fall_lead), 1316);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
